// File: rtl/aerout_axis_tx.sv
// AEROUT 4-phase slave feeding a FIFO, drained as 2-byte AXI-Stream frames
// ({0x3, 00, addr[9:8]} then addr[7:0] with tlast) toward the host link.
module aerout_axis_tx #(
    parameter int AER_W = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [AER_W-1:0]         AEROUT_ADDR,
    input  logic                     AEROUT_REQ,
    output logic                     AEROUT_ACK,
    output logic [7:0]               m_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     m_axis_tlast,
    output logic [$clog2(DEPTH):0]   FIFO_LEVEL,
    output logic [15:0]              EVT_CNT
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        ADDR = 2'd2
    } tx_state_e;

    // Valid/ready: a byte transfers on any rising edge where m_axis_tvalid and
    // m_axis_tready are both high; once tvalid is raised, tdata/tlast/tvalid
    // stay unchanged until that transfer happens.

    tx_state_e          state_q, state_d;
    logic               ack_q, ack_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic [7:0]         tdata_q, tdata_d;
    logic               tvalid_q, tvalid_d;
    logic               tlast_q, tlast_d;
    logic [9:0]         cur_addr_q, cur_addr_d;
    logic [15:0]        evt_cnt_q, evt_cnt_d;
    logic [AER_W-1:0]   mem_q [DEPTH];

    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic [9:0]         head_addr;

    function automatic logic [9:0] ext10(input logic [AER_W-1:0] a);
        logic [9:0] r;
        r = '0;
        r[AER_W-1:0] = a;
        return r;
    endfunction

    // Full/empty come from the registered level only, so a pop this cycle
    // cannot open a slot for a push in the same cycle.
    assign fifo_full  = (level_q == LVL_W'(DEPTH));
    assign fifo_empty = (level_q == '0);
    assign push       = AEROUT_REQ && !ack_q && !fifo_full;
    assign head_addr  = ext10(mem_q[rd_ptr_q]);

    always_comb begin
        ack_d = ack_q;
        if (push) begin
            ack_d = 1'b1;
        end else if (!AEROUT_REQ && ack_q) begin
            ack_d = 1'b0;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (!push && pop) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    always_comb begin
        state_d    = state_q;
        tdata_d    = tdata_q;
        tvalid_d   = tvalid_q;
        tlast_d    = tlast_q;
        cur_addr_d = cur_addr_q;
        evt_cnt_d  = evt_cnt_q;
        pop        = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    cur_addr_d = head_addr;
                    tdata_d    = {4'b0011, 2'b00, head_addr[9:8]};
                    tvalid_d   = 1'b1;
                    tlast_d    = 1'b0;
                    state_d    = HDR;
                end
            end
            HDR: begin
                if (m_axis_tready) begin
                    tdata_d = cur_addr_q[7:0];
                    tlast_d = 1'b1;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (m_axis_tready) begin
                    evt_cnt_d = evt_cnt_q + 16'd1;
                    // Chain straight into the next header so the stream has no bubble.
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        cur_addr_d = head_addr;
                        tdata_d    = {4'b0011, 2'b00, head_addr[9:8]};
                        tlast_d    = 1'b0;
                        state_d    = HDR;
                    end else begin
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                        state_d  = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ack_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            tdata_q    <= 8'h00;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            cur_addr_q <= '0;
            evt_cnt_q  <= 16'h0000;
        end else begin
            state_q    <= state_d;
            ack_q      <= ack_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            tdata_q    <= tdata_d;
            tvalid_q   <= tvalid_d;
            tlast_q    <= tlast_d;
            cur_addr_q <= cur_addr_d;
            evt_cnt_q  <= evt_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= AEROUT_ADDR;
        end
    end

    assign AEROUT_ACK    = ack_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign FIFO_LEVEL    = level_q;
    assign EVT_CNT       = evt_cnt_q;

endmodule

// File: tb/tb_aerout_axis_tx.sv
// Bench for aerout_axis_tx: AEROUT driver tasks, a frame-level reference
// model feeding an expected-byte queue, and a negedge stream monitor.
module tb_aerout_axis_tx;

    localparam int AER_W = 10;
    localparam int DEPTH = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [AER_W-1:0] aer_addr;
    logic             aer_req;
    logic             aer_ack;
    logic [7:0]       tdata;
    logic             tvalid;
    logic             tready;
    logic             tlast;
    logic [4:0]       fifo_level;
    logic [15:0]      evt_cnt;

    int tests = 0;
    int fails = 0;
    int exp_evt = 0;
    logic [8:0] exp_q[$];

    aerout_axis_tx #(.AER_W(AER_W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .AEROUT_ADDR  (aer_addr),
        .AEROUT_REQ   (aer_req),
        .AEROUT_ACK   (aer_ack),
        .m_axis_tdata (tdata),
        .m_axis_tvalid(tvalid),
        .m_axis_tready(tready),
        .m_axis_tlast (tlast),
        .FIFO_LEVEL   (fifo_level),
        .EVT_CNT      (evt_cnt)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: each accepted event becomes two stream beats.
    task automatic model_event(input logic [9:0] a);
        logic [8:0] b0;
        logic [8:0] b1;
        b0 = {1'b0, 8'(8'h30 + (a >> 8))};
        b1 = {1'b1, 8'(a % 256)};
        exp_q.push_back(b0);
        exp_q.push_back(b1);
        exp_evt = exp_evt + 1;
    endtask

    // 4-phase handshake; returns cycles to ACK rise and ACK fall.
    task automatic send_event(input logic [9:0] a, output int rise, output int fall);
        aer_addr = a;
        aer_req  = 1'b1;
        rise = 0;
        while (!aer_ack && rise < 400) begin
            tick();
            rise++;
        end
        if (!aer_ack) begin
            tests++;
            fails++;
            $display("FAIL ack_rise_timeout: ack=%0b after %0d cycles, expected 1", aer_ack, rise);
            aer_req = 1'b0;
            return;
        end
        model_event(a);
        aer_req = 1'b0;
        fall = 0;
        while (aer_ack && fall < 20) begin
            tick();
            fall++;
        end
        check("ack_release", 32'(aer_ack), 32'd0);
    endtask

    task automatic send(input logic [9:0] a);
        int r;
        int f;
        send_event(a, r, f);
    endtask

    task automatic drain(input string name);
        int n;
        tready = 1'b1;
        n = 0;
        while ((exp_q.size() != 0 || tvalid) && n < 500) begin
            tick();
            n++;
        end
        check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
        check({name, "_tvalid_idle"}, 32'(tvalid), 32'd0);
        check({name, "_evt_cnt"}, 32'(evt_cnt), 32'(16'(exp_evt)));
    endtask

    // Scoreboard monitor: a beat seen at negedge transfers on the next posedge.
    initial begin : monitor
        logic [9:0] prev_out;
        logic [8:0] e;
        bit         prev_hold;
        prev_hold = 1'b0;
        prev_out  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_hold = 1'b0;
            end else begin
                if (prev_hold) begin
                    check("axis_hold_stable", 32'({tvalid, tlast, tdata}), 32'(prev_out));
                end
                if (tvalid && tready) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_beat: got 0x%0h, expected no beat", {tlast, tdata});
                    end else begin
                        e = exp_q.pop_front();
                        check("beat", 32'({tlast, tdata}), 32'(e));
                    end
                end
                prev_hold = tvalid && !tready;
                prev_out  = {tvalid, tlast, tdata};
            end
        end
    end

    initial begin : stimulus
        int  rise;
        int  fall;
        bit  rnd_on;

        rst      = 1'b1;
        aer_req  = 1'b0;
        aer_addr = '0;
        tready   = 1'b0;
        repeat (3) tick();
        check("rst_ack", 32'(aer_ack), 32'd0);
        check("rst_tdata", 32'(tdata), 32'd0);
        check("rst_tvalid", 32'(tvalid), 32'd0);
        check("rst_tlast", 32'(tlast), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_evt_cnt", 32'(evt_cnt), 32'd0);
        rst = 1'b0;
        tick();

        // Single event with latency checks
        tready = 1'b1;
        send_event(10'h0A5, rise, fall);
        check("t1_ack_rise_latency", 32'(rise), 32'd1);
        check("t1_ack_fall_latency", 32'(fall), 32'd1);
        drain("t1");

        // Back-to-back frames with continuous tvalid
        tready = 1'b0;
        send(10'h001);
        send(10'h002);
        send(10'h003);
        tready = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("t2_tvalid_continuous", 32'(tvalid), 32'd1);
        end
        tick();
        drain("t2");

        // Backpressure in both header and address phases
        tready = 1'b0;
        send(10'h15A);
        repeat (10) tick();
        tready = 1'b1;
        tick();
        tready = 1'b0;
        check("t3_in_addr_phase", 32'({tvalid, tlast}), 32'd3);
        repeat (10) tick();
        drain("t3");

        // Full FIFO: one event sits in the TX stage, DEPTH more fill the FIFO
        tready = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            send(10'(32'h100 + i * 7));
        end
        repeat (2) tick();
        check("t4_level_full", 32'(fifo_level), 32'(DEPTH));
        fork
            send(10'h2C3);
            begin
                repeat (5) tick();
                check("t4_ack_withheld", 32'(aer_ack), 32'd0);
                check("t4_level_still_full", 32'(fifo_level), 32'(DEPTH));
                tready = 1'b1;
            end
        join
        drain("t4");

        // Full 10-bit address
        send(10'h3FF);
        drain("t5");

        // Reset while sending the address byte with queued events
        tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send(10'(32'h040 + i));
        end
        tready = 1'b1;
        tick();
        tready = 1'b0;
        check("t6_pre_level", 32'(fifo_level), 32'd4);
        check("t6_pre_addr_phase", 32'({tvalid, tlast}), 32'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        exp_evt = 0;
        check("t6_tvalid", 32'(tvalid), 32'd0);
        check("t6_ack", 32'(aer_ack), 32'd0);
        check("t6_level", 32'(fifo_level), 32'd0);
        check("t6_evt_cnt", 32'(evt_cnt), 32'd0);
        tick();
        tready = 1'b1;
        send(10'h0C7);
        drain("t6_after");

        // Random addresses with random sink backpressure
        rnd_on = 1'b1;
        fork
            begin
                while (rnd_on) begin
                    tready = 1'($urandom_range(0, 1));
                    tick();
                end
            end
            begin
                for (int i = 0; i < 30; i++) begin
                    send(10'($urandom_range(0, 1023)));
                    repeat ($urandom_range(0, 3)) tick();
                end
                rnd_on = 1'b0;
            end
        join
        drain("t7");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
